// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM controller.
// Grants one access at a time, drives the controller handshake and aborts accesses that stall.
module ram_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int SETTLE  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [22:0] addr0,
  input  logic [22:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic [1:0]  done,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr,
  output logic        Instruction,
  output logic        latch,
  output logic [22:0] ramBusAddr,
  output logic [15:0] ramBusDataIn,
  input  logic [15:0] ramBusDataOut,
  input  logic        Ready
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    ST_SETTLE, ST_IDLE, ST_ISSUE, ST_WAIT_ACCEPT, ST_WAIT_DONE, ST_COMPLETE
  } state_t;

  state_t      r_state;
  logic [SW-1:0] r_settle;
  // Wait counter is sized so it can actually reach TIMEOUT.
  logic [WW-1:0] r_wait;
  logic        r_last;
  logic        r_grant;
  logic        r_latch;
  logic        r_instr;
  logic [22:0] r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_done;
  logic [15:0] r_rdata;
  logic        r_busy;
  logic        r_err;

  logic w_pick;
  logic w_expire;
  logic w_abort;

  // A tie goes to the requester that was not served last.
  assign w_pick   = req[1] & (~req[0] | ~r_last);
  assign w_expire = (r_wait == WW'(TIMEOUT - 1));
  assign w_abort  = w_expire &
                    (((r_state == ST_WAIT_ACCEPT) & Ready) |
                     ((r_state == ST_WAIT_DONE) & ~Ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_SETTLE;
      r_settle <= '0;
      r_wait   <= '0;
      r_last   <= 1'b1;
      r_grant  <= 1'b0;
      r_latch  <= 1'b0;
      r_instr  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_done   <= 2'b00;
      r_rdata  <= '0;
      r_busy   <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_latch <= 1'b0;
      r_done  <= 2'b00;
      r_err   <= w_abort | (r_err & ~err_clr);
      case (r_state)
        ST_SETTLE: begin
          if (r_settle == SW'(SETTLE - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        ST_IDLE: begin
          if (req != 2'b00) begin
            r_grant <= w_pick;
            r_instr <= w_pick ? we[1] : we[0];
            r_addr  <= w_pick ? addr1 : addr0;
            r_wdata <= w_pick ? wdata1 : wdata0;
            r_latch <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wait  <= '0;
          r_state <= ST_WAIT_ACCEPT;
        end
        ST_WAIT_ACCEPT: begin
          if (!Ready) begin
            r_state <= ST_WAIT_DONE;
            r_wait  <= r_wait + WW'(1);
          end else if (w_abort) begin
            r_state <= ST_COMPLETE;
            r_done  <= r_grant ? 2'b10 : 2'b01;
            r_rdata <= 16'hDEAD;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (Ready) begin
            r_state <= ST_COMPLETE;
            r_done  <= r_grant ? 2'b10 : 2'b01;
            if (!r_instr) r_rdata <= ramBusDataOut;
          end else if (w_abort) begin
            r_state <= ST_COMPLETE;
            r_done  <= r_grant ? 2'b10 : 2'b01;
            r_rdata <= 16'hDEAD;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        ST_COMPLETE: begin
          r_last  <= r_grant;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_SETTLE;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign done         = r_done;
  assign rdata        = r_rdata;
  assign busy         = r_busy;
  assign timeout_err  = r_err;
  assign Instruction  = r_instr;
  assign latch        = r_latch;
  assign ramBusAddr   = r_addr;
  assign ramBusDataIn = r_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a small RAM controller model answers each latch,
// and every expected done/rdata pair is queued when the request is driven.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [22:0] addr0 = '0;
  logic [22:0] addr1 = '0;
  logic [15:0] wdata0 = '0;
  logic [15:0] wdata1 = '0;
  logic [1:0]  done;
  logic [15:0] rdata;
  logic        busy;
  logic        timeout_err;
  logic        err_clr = 1'b0;
  logic        Instruction;
  logic        latch;
  logic [22:0] ramBusAddr;
  logic [15:0] ramBusDataIn;
  logic [15:0] ramBusDataOut = '0;
  logic        Ready = 1'b1;

  ram_arbiter #(.TIMEOUT(64), .SETTLE(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .rdata(rdata), .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr), .Instruction(Instruction), .latch(latch),
    .ramBusAddr(ramBusAddr), .ramBusDataIn(ramBusDataIn),
    .ramBusDataOut(ramBusDataOut), .Ready(Ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nPass = 0;

  typedef struct {
    logic [1:0]  done;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sbQ[$];

  function automatic logic [15:0] rdFor(input logic [22:0] a);
    return a[15:0] ^ 16'h1224;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic pushExp(input logic [1:0] d, input logic [15:0] r, input int c);
    exp_t e;
    e.done = d;
    e.rdata = r;
    e.cyc = c;
    sbQ.push_back(e);
  endtask

  // Controller model: Ready falls the cycle after latch, rises 5 cycles later with data.
  logic       stuck = 1'b0;
  logic [3:0] ctlCnt = '0;
  logic [22:0] ctlAddr = '0;
  always @(posedge clk) begin
    if (latch && !stuck && ctlCnt == 0) begin
      Ready   <= 1'b0;
      ctlCnt  <= 4'd5;
      ctlAddr <= ramBusAddr;
    end else if (ctlCnt != 0) begin
      ctlCnt <= ctlCnt - 4'd1;
      if (ctlCnt == 4'd1) begin
        Ready         <= 1'b1;
        ramBusDataOut <= rdFor(ctlAddr);
      end
    end
  end

  always @(negedge clk) begin
    if (done != 2'b00) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected done", {30'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("done grant", {30'd0, done}, {30'd0, e.done});
        checkOutput("rdata", {16'd0, rdata}, {16'd0, e.rdata});
        if (e.cyc >= 0) checkOutput("done latency", cyc, e.cyc);
      end
    end
  end

  task automatic waitIdle(input int maxC);
    for (int i = 0; i < maxC; i++) begin
      @(negedge clk); #1;
      if (!busy) return;
    end
    checkOutput("idle wait expired", 1, 0);
  endtask

  task automatic waitLatch(input int maxC);
    for (int i = 0; i < maxC; i++) begin
      @(negedge clk); #1;
      if (latch) return;
    end
    checkOutput("latch wait expired", 1, 0);
  endtask

  task automatic waitDrain(input int maxC);
    for (int i = 0; i < maxC; i++) begin
      @(negedge clk); #1;
      if (sbQ.size() == 0) return;
    end
    checkOutput("done wait expired", sbQ.size(), 0);
    sbQ.delete();
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w);
    we  = w;
    req = r;
  endtask

  initial begin
    int relCyc;
    @(negedge clk); #1;
    checkOutput("reset busy", busy, 1);
    checkOutput("reset latch", latch, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset rdata", rdata, 0);
    checkOutput("reset err", timeout_err, 0);
    checkOutput("reset instr", Instruction, 0);
    checkOutput("reset addr", ramBusAddr, 0);
    checkOutput("reset wdata", ramBusDataIn, 0);

    // Tie in the very first IDLE, then six held accesses alternate 0,1,0,1,0,1.
    addr0 = 23'h000100;
    addr1 = 23'h000200;
    relCyc = cyc;
    rst_n = 1'b1;
    applyStimulus(2'b11, 2'b00);
    for (int i = 0; i < 6; i++)
      pushExp((i % 2) ? 2'b10 : 2'b01, (i % 2) ? rdFor(addr1) : rdFor(addr0),
              (i == 0) ? relCyc + 16 : -1);
    waitLatch(30);
    checkOutput("settle holdoff", cyc, relCyc + 9);
    waitDrain(200);
    req = 2'b00;

    // Single read.
    waitIdle(10);
    addr0 = 23'h000010;
    pushExp(2'b01, 16'h1234, cyc + 8);
    applyStimulus(2'b01, 2'b00);
    waitDrain(30);
    req = 2'b00;

    // Single write; rdata keeps the last read value.
    waitIdle(10);
    addr1  = 23'h7FFFFF;
    wdata1 = 16'hA5A5;
    pushExp(2'b10, 16'h1234, cyc + 8);
    applyStimulus(2'b10, 2'b10);
    waitLatch(5);
    checkOutput("write instr", Instruction, 1);
    checkOutput("write addr", ramBusAddr, 32'h7FFFFF);
    checkOutput("write data", ramBusDataIn, 32'hA5A5);
    @(negedge clk); #1;
    checkOutput("latch width", latch, 0);
    checkOutput("addr hold", ramBusAddr, 32'h7FFFFF);
    waitDrain(30);
    applyStimulus(2'b00, 2'b00);

    // Requester 0 withdraws mid-access; its done still arrives, then requester 1.
    waitIdle(10);
    addr0 = 23'h000020;
    addr1 = 23'h000030;
    pushExp(2'b01, rdFor(addr0), -1);
    pushExp(2'b10, rdFor(addr1), -1);
    applyStimulus(2'b11, 2'b00);
    waitLatch(5);
    repeat (3) @(negedge clk);
    #1 req = 2'b10;
    waitDrain(60);
    req = 2'b00;

    // Controller never accepts: access aborts after the wait budget.
    waitIdle(10);
    stuck = 1'b1;
    addr0 = 23'h000040;
    pushExp(2'b01, 16'hDEAD, cyc + 66);
    applyStimulus(2'b01, 2'b00);
    waitDrain(100);
    req = 2'b00;
    checkOutput("timeout err set", timeout_err, 1);
    @(negedge clk); #1;
    checkOutput("timeout err sticky", timeout_err, 1);
    err_clr = 1'b1;
    @(negedge clk); #1;
    err_clr = 1'b0;
    checkOutput("timeout err clear", timeout_err, 0);
    stuck = 1'b0;

    // Reset during WAIT_DONE: no done, immediate outputs, settle before next grant.
    waitIdle(10);
    addr0 = 23'h000050;
    applyStimulus(2'b01, 2'b00);
    waitLatch(5);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset latch", latch, 0);
    checkOutput("midreset done", done, 0);
    checkOutput("midreset busy", busy, 1);
    checkOutput("midreset rdata", rdata, 0);
    @(negedge clk); #1;
    relCyc = cyc;
    rst_n = 1'b1;
    pushExp(2'b01, rdFor(addr0), relCyc + 16);
    waitLatch(30);
    checkOutput("post-reset holdoff", cyc, relCyc + 9);
    waitDrain(30);
    req = 2'b00;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
